lsu_ctrl: RTL

Load/store access controller sitting between the execute stage and the data-memory port. Accepts one load or store at a time from the pipeline, forms the effective address (base + sign-extended 12-bit immediate), checks alignment and funct3 legality, and sequences a request/grant/response transaction on the data-memory bus. Handles byte-lane steering for stores, lane extraction with sign/zero extension for loads, and a response timeout, then returns a single-cycle result to writeback.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes, response error codes and legality helpers for the
// load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Unsigned load widths have no store counterpart.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

  // funct3[1:0] encodes access size for every legal code.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension
// for loads; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be    = '1;
    wdata = rs2;
    if (store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << off;
          wdata = {2{rs2[15:0]}};
        end
        default: begin
          be    = '1;
          wdata = rs2;
        end
      endcase
    end
  end

  always_comb begin
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
      F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
      F3_BU:   ldata = {24'h000000, lane_b};
      F3_HU:   ldata = {16'h0000, lane_h};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store access controller: effective-address formation, legality checks,
// request/grant/response sequencing with timeout, single-cycle result pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_imm,
  input  logic [31:0] req_base,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  f3_r;
  logic        store_r;
  logic [1:0]  off_r;
  logic [4:0]  rd_r;

  logic [31:0] ea;
  logic        idle;
  logic        cnt_last;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;

  assign ea        = req_base + {{20{req_imm[11]}}, req_imm};
  assign idle      = (state == S_IDLE);
  assign cnt_last  = (cnt == CNT_LAST);
  assign req_ready = idle;
  assign busy      = !idle;

  // One aligner serves both phases: live request fields steer store lanes at
  // acceptance, captured fields select the load lane while waiting.
  assign al_store = idle ? req_store     : store_r;
  assign al_f3    = idle ? req_funct3    : f3_r;
  assign al_off   = idle ? ea[1:0]       : off_r;

  lsu_align u_align (
    .store  (al_store),
    .funct3 (al_f3),
    .off    (al_off),
    .rs2    (req_wdata),
    .rdata  (mem_rdata),
    .be     (al_be),
    .wdata  (al_wdata),
    .ldata  (al_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_r      <= '0;
      store_r   <= 1'b0;
      off_r     <= '0;
      rd_r      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_r    <= req_funct3;
            store_r <= req_store;
            off_r   <= ea[1:0];
            rd_r    <= req_rd;
            cnt     <= '0;
            if (!f3_legal(req_store, req_funct3)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_ILLEGAL;
              rsp_data  <= '0;
              rsp_rd    <= req_rd;
              state     <= S_DONE;
            end else if (f3_misaligned(req_funct3, ea[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_MISALIGN;
              rsp_data  <= '0;
              rsp_rd    <= req_rd;
              state     <= S_DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= {ea[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= req_store ? al_wdata : '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Timeout wins over a grant arriving on the final budgeted cycle.
          if (cnt_last) begin
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_data  <= '0;
            rsp_rd    <= rd_r;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
            if (mem_gnt) begin
              mem_req <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_OK;
            rsp_data  <= store_r ? '0 : al_ldata;
            rsp_rd    <= rd_r;
            state     <= S_DONE;
          end else if (cnt_last) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_TIMEOUT;
            rsp_data  <= '0;
            rsp_rd    <= rd_r;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
